// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter.
//   REG_WIDTH  - register data width (must match regfile)
//   NUM_REGS   - number of architectural registers (width of pend_mask)
//   wb_entry_t - one queued register-file write (destination + data)
//   rd_onehot  - one-hot decode of a destination register index
package wb_pkg;

  localparam int REG_WIDTH = 64;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [4:0]           rd;
    logic [REG_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [4:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer with two push ports and one pop port.
//   clk, reset              - clock, synchronous active-high reset
//   push0 / push0_entry     - first push slot (older of a same-cycle pair)
//   push1 / push1_entry     - second push slot (younger of a same-cycle pair)
//   pop                     - remove the head entry (caller guarantees count > 0)
//   head                    - current head entry (valid when count > 0)
//   count                   - registered occupancy
//   entry_vld / entry_rd    - per-slot valid bits and destinations for hazard masks
// The caller guarantees room for every push; no overflow protection here.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push0,
  input  wb_entry_t              push0_entry,
  input  logic                   push1,
  input  wb_entry_t              push1_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [PW:0]            count,
  output logic [QDEPTH-1:0]      entry_vld,
  output logic [QDEPTH-1:0][4:0] entry_rd
);

  wb_entry_t         mem_q [QDEPTH];
  wb_entry_t         mem_d [QDEPTH];
  logic [QDEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW:0]       count_q, count_d;
  logic [PW-1:0]     wptr1;

  // The second push lands one slot later only when the first push is also active.
  assign wptr1 = wptr_q + PW'(push0);

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    // Clear before set: a popped slot can be refilled on the same edge.
    if (pop) vld_d[rptr_q] = 1'b0;
    if (push0) begin
      mem_d[wptr_q] = push0_entry;
      vld_d[wptr_q] = 1'b1;
    end
    if (push1) begin
      mem_d[wptr1] = push1_entry;
      vld_d[wptr1] = 1'b1;
    end
    wptr_d  = wptr_q + PW'(push0) + PW'(push1);
    rptr_d  = rptr_q + PW'(pop);
    count_d = count_q + (PW+1)'(push0) + (PW+1)'(push1) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head      = mem_q[rptr_q];
  assign count     = count_q;
  assign entry_vld = vld_q;

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_rd
    assign entry_rd[gi] = mem_q[gi].rd;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges load and ALU results onto the single regfile write port.
//   clk, reset                            - clock, synchronous active-high reset
//   mem_valid/mem_ready/mem_rd/mem_data   - load result handshake
//   alu_valid/alu_ready/alu_rd/alu_data   - ALU result handshake
//   rd/rd_din/reg_write                   - registered regfile write port
//   pend_mask                             - destinations queued or in the output stage
// Optional feature macro: WB_X0_FILTER_EN - drop writes to x0 after handshaking.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int REG_WIDTH = 64,
  parameter int QDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [4:0]           mem_rd,
  input  logic [REG_WIDTH-1:0] mem_data,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [4:0]           alu_rd,
  input  logic [REG_WIDTH-1:0] alu_data,
  output logic [4:0]           rd,
  output logic [REG_WIDTH-1:0] rd_din,
  output logic                 reg_write,
  output logic [NUM_REGS-1:0]  pend_mask
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [CW-1:0]                    count;
  wb_entry_t                        head;
  wb_entry_t                        mem_entry, alu_entry;
  logic [QDEPTH-1:0]                entry_vld;
  logic [QDEPTH-1:0][4:0]           entry_rd;
  logic [QDEPTH-1:0][NUM_REGS-1:0]  entry_mask;
  logic                             mem_push, alu_push, pop;

  logic                 reg_write_q, reg_write_d;
  logic [4:0]           rd_q, rd_d;
  logic [REG_WIDTH-1:0] rd_din_q, rd_din_d;

  // Readies look only at registered occupancy; ALU keeps one slot in reserve so
  // both sources can be accepted together without overflow.
  assign mem_ready = !reset && (count <= CW'(QDEPTH - 1));
  assign alu_ready = !reset && (count <= CW'(QDEPTH - 2));

`ifdef WB_X0_FILTER_EN
  assign mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
`else
  assign mem_push = mem_valid && mem_ready;
  assign alu_push = alu_valid && alu_ready;
`endif

  assign mem_entry = '{rd: mem_rd, data: mem_data};
  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign pop       = (count != '0);

  // Load goes into the older slot so a same-cycle pair drains mem first.
  wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push0       (mem_push),
    .push0_entry (mem_entry),
    .push1       (alu_push),
    .push1_entry (alu_entry),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_vld   (entry_vld),
    .entry_rd    (entry_rd)
  );

  always_comb begin
    reg_write_d = pop;
    rd_d        = pop ? head.rd   : rd_q;
    rd_din_d    = pop ? head.data : rd_din_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      rd_din_q    <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      rd_din_q    <= rd_din_d;
    end
  end

  assign reg_write = reg_write_q;
  assign rd        = rd_q;
  assign rd_din    = rd_din_q;

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_mask
    assign entry_mask[gi] = entry_vld[gi] ? rd_onehot(entry_rd[gi]) : '0;
  end

  always_comb begin
    pend_mask = reg_write_q ? rd_onehot(rd_q) : '0;
    for (int i = 0; i < QDEPTH; i++) begin
      pend_mask = pend_mask | entry_mask[i];
    end
`ifdef WB_X0_FILTER_EN
    pend_mask[0] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter (QDEPTH=4).
// Inputs are driven 1 time unit after the falling edge; outputs are sampled there too.
// A monitor logs every regfile write seen on the falling edge.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic        mem_ready, alu_ready;
  logic [4:0]  mem_rd, alu_rd, rd;
  logic [63:0] mem_data, alu_data, rd_din;
  logic        reg_write;
  logic [31:0] pend_mask;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [63:0] rf [32];

  always #5 clk = ~clk;

  wb_arbiter #(.REG_WIDTH(64), .QDEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .rd        (rd),
    .rd_din    (rd_din),
    .reg_write (reg_write),
    .pend_mask (pend_mask)
  );

  // Regfile model: one line per committed write.
  always @(negedge clk) begin
    if (reg_write === 1'b1) begin
      wr_q.push_back('{rd: rd, data: rd_din});
      rf[rd] <= rd_din;
      $display("write x%0d <= %h", rd, rd_din);
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
    mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
    nxt(); nxt();
    n_chk++; if (reg_write !== 1'b0) $display("FAIL reset_reg_write: got %b want 0", reg_write); else n_pass++;
    n_chk++; if (rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", rd); else n_pass++;
    n_chk++; if (rd_din !== 64'd0) $display("FAIL reset_rd_din: got %h want 0", rd_din); else n_pass++;
    n_chk++; if (pend_mask !== 32'd0) $display("FAIL reset_pend: got %h want 0", pend_mask); else n_pass++;
    n_chk++; if (mem_ready !== 1'b0) $display("FAIL reset_mem_ready: got %b want 0", mem_ready); else n_pass++;
    n_chk++; if (alu_ready !== 1'b0) $display("FAIL reset_alu_ready: got %b want 0", alu_ready); else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (mem_ready !== 1'b1) $display("FAIL release_mem_ready: got %b want 1", mem_ready); else n_pass++;
    n_chk++; if (alu_ready !== 1'b1) $display("FAIL release_alu_ready: got %b want 1", alu_ready); else n_pass++;
  endtask

  task automatic test_single_alu();
    wr_q.delete();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
    #1;
    n_chk++; if (alu_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", alu_ready); else n_pass++;
    nxt();
    alu_valid = 1'b0;
    n_chk++; if (reg_write !== 1'b0) $display("FAIL single_wr_early: got %b want 0", reg_write); else n_pass++;
    n_chk++; if (pend_mask !== 32'h20) $display("FAIL single_pend_q: got %h want 00000020", pend_mask); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b1) $display("FAIL single_wr: got %b want 1", reg_write); else n_pass++;
    n_chk++; if (rd !== 5'd5) $display("FAIL single_rd: got %0d want 5", rd); else n_pass++;
    n_chk++; if (rd_din !== 64'hDEAD) $display("FAIL single_din: got %h want dead", rd_din); else n_pass++;
    n_chk++; if (pend_mask !== 32'h20) $display("FAIL single_pend_out: got %h want 00000020", pend_mask); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b0) $display("FAIL single_wr_drop: got %b want 0", reg_write); else n_pass++;
    n_chk++; if (pend_mask !== 32'h0) $display("FAIL single_pend_clr: got %h want 0", pend_mask); else n_pass++;
    n_chk++; if (rd !== 5'd5) $display("FAIL single_rd_hold: got %0d want 5", rd); else n_pass++;
    n_chk++; if (wr_q.size() != 1) $display("FAIL single_count: got %0d writes want 1", wr_q.size()); else n_pass++;
  endtask

  task automatic test_same_rd();
    wr_q.delete();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h2;
    nxt();
    mem_valid = 1'b0; alu_valid = 1'b0;
    n_chk++; if (pend_mask !== 32'h80) $display("FAIL same_pend: got %h want 00000080", pend_mask); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b1 || rd !== 5'd7 || rd_din !== 64'h1) $display("FAIL same_first: got we=%b rd=%0d din=%h want we=1 rd=7 din=1", reg_write, rd, rd_din); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b1 || rd !== 5'd7 || rd_din !== 64'h2) $display("FAIL same_second: got we=%b rd=%0d din=%h want we=1 rd=7 din=2", reg_write, rd, rd_din); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b0) $display("FAIL same_drop: got %b want 0", reg_write); else n_pass++;
    n_chk++; if (rf[7] !== 64'h2) $display("FAIL same_rf_x7: got %h want 2", rf[7]); else n_pass++;
  endtask

  task automatic test_backpressure();
    wr_t         exp_q[$];
    int          acc = 0;
    int          cnt = 0;
    int          cyc = 0;
    logic        m_acc, a_acc;
    logic [63:0] seq = 64'h1000;
    wr_q.delete();
    mem_valid = 1'b1; mem_rd = 5'($urandom_range(1, 31)); mem_data = seq; seq++;
    alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_data = seq; seq++;
    while (acc < 100 && cyc < 500) begin
      n_chk++; if (mem_ready !== (cnt <= 3)) $display("FAIL bp_mem_ready: cyc %0d got %b want %b (count %0d)", cyc, mem_ready, (cnt <= 3), cnt); else n_pass++;
      n_chk++; if (alu_ready !== (cnt <= 2)) $display("FAIL bp_alu_ready: cyc %0d got %b want %b (count %0d)", cyc, alu_ready, (cnt <= 2), cnt); else n_pass++;
      m_acc = mem_ready;
      a_acc = alu_ready;
      if (m_acc) begin exp_q.push_back('{rd: mem_rd, data: mem_data}); acc++; end
      if (a_acc) begin exp_q.push_back('{rd: alu_rd, data: alu_data}); acc++; end
      cnt = cnt + int'(m_acc) + int'(a_acc) - ((cnt > 0) ? 1 : 0);
      nxt();
      cyc++;
      if (m_acc) begin mem_rd = 5'($urandom_range(1, 31)); mem_data = seq; seq++; end
      if (a_acc) begin alu_rd = 5'($urandom_range(1, 31)); alu_data = seq; seq++; end
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    n_chk++; if (acc < 100) $display("FAIL bp_timeout: got %0d transfers want 100", acc); else n_pass++;
    repeat (8) nxt();
    n_chk++; if (wr_q.size() != exp_q.size()) $display("FAIL bp_count: got %0d writes want %0d", wr_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_chk++; if (wr_q[i] !== exp_q[i]) $display("FAIL bp_entry%0d: got x%0d=%h want x%0d=%h", i, wr_q[i].rd, wr_q[i].data, exp_q[i].rd, exp_q[i].data); else n_pass++;
    end
    n_chk++; if (pend_mask !== 32'h0) $display("FAIL bp_pend_idle: got %h want 0", pend_mask); else n_pass++;
  endtask

  task automatic test_x0();
    wr_q.delete();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h55;
    #1;
    n_chk++; if (alu_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", alu_ready); else n_pass++;
    nxt();
    alu_valid = 1'b0;
`ifdef WB_X0_FILTER_EN
    n_chk++; if (pend_mask !== 32'h0) $display("FAIL x0_pend: got %h want 0", pend_mask); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b0) $display("FAIL x0_wr: got %b want 0", reg_write); else n_pass++;
    n_chk++; if (pend_mask !== 32'h0) $display("FAIL x0_pend_out: got %h want 0", pend_mask); else n_pass++;
    nxt();
    n_chk++; if (wr_q.size() != 0) $display("FAIL x0_count: got %0d writes want 0", wr_q.size()); else n_pass++;
`else
    n_chk++; if (pend_mask !== 32'h1) $display("FAIL x0_pend: got %h want 00000001", pend_mask); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b1 || rd !== 5'd0 || rd_din !== 64'h55) $display("FAIL x0_wr: got we=%b rd=%0d din=%h want we=1 rd=0 din=55", reg_write, rd, rd_din); else n_pass++;
    nxt();
    n_chk++; if (wr_q.size() != 1) $display("FAIL x0_count: got %0d writes want 1", wr_q.size()); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'hA3;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hA4;
    nxt();
    mem_rd = 5'd8; mem_data = 64'hA8;
    alu_rd = 5'd9; alu_data = 64'hA9;
    nxt();
    mem_valid = 1'b0; alu_valid = 1'b0;
    // x3 in the output stage, x4/x8/x9 still queued.
    n_chk++; if (pend_mask !== 32'h318) $display("FAIL mid_pend_full: got %h want 00000318", pend_mask); else n_pass++;
    n_chk++; if (alu_ready !== 1'b0) $display("FAIL mid_alu_full: got %b want 0", alu_ready); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (mem_ready !== 1'b0) $display("FAIL mid_mem_ready_rst: got %b want 0", mem_ready); else n_pass++;
    nxt();
    n_chk++; if (reg_write !== 1'b0) $display("FAIL mid_wr: got %b want 0", reg_write); else n_pass++;
    n_chk++; if (pend_mask !== 32'h0) $display("FAIL mid_pend: got %h want 0", pend_mask); else n_pass++;
    n_chk++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) $display("FAIL mid_readies: got %b%b want 00", mem_ready, alu_ready); else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++; if (mem_ready !== 1'b1) $display("FAIL mid_release: got %b want 1", mem_ready); else n_pass++;
    wr_q.delete();
    repeat (6) nxt();
    n_chk++; if (wr_q.size() != 0) $display("FAIL mid_stale: got %0d writes want 0", wr_q.size()); else n_pass++;
    n_chk++; if (pend_mask !== 32'h0) $display("FAIL mid_pend_after: got %h want 0", pend_mask); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_same_rd();
    test_backpressure();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
